wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001: Parameter DATA_W, default 64, write-data width.
REQ-002: Parameter STARVE_MAX, default 4, consecutive lost cycles before requester B gets priority; legal range 1..15.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset_n  input  1  asynchronous, active-low reset.
REQ-005: a_valid  input  1  pipeline writeback request (requester A).
REQ-006: a_addr  input  5  A destination register.
REQ-007: a_data  input  DATA_W  A write data.
REQ-008: a_ready  output  1  A request accepted this cycle.
REQ-009: b_valid  input  1  long-latency unit request (requester B).
REQ-010: b_addr  input  5  B destination register.
REQ-011: b_data  input  DATA_W  B write data.
REQ-012: b_ready  output  1  B request accepted this cycle.
REQ-013: wr_en  output  1  register-file write enable, registered.
REQ-014: wr_sel  output  1  select for the 5-bit 2:1 destination mux and the data mux (0 = A, 1 = B), registered.
REQ-015: wr_addr  output  5  registered destination address.
REQ-016: wr_data  output  DATA_W  registered write data.
REQ-017: boost  output  1  high while in state BOOST (debug/observability).

Function
REQ-018: A transfer occurs on a cycle where valid and ready are both high; at most one transfer per cycle.
REQ-019: a_ready and b_ready are combinational from the valid inputs and the current state, and are never both high on the same cycle.
REQ-020: The block has two states: NORM (A has priority) and BOOST (B has priority). It also has a starvation counter, starve_cnt, that is 4 bits wide.
REQ-021: In NORM: a_ready = 1; b_ready = !a_valid.
REQ-022: In BOOST: b_ready = 1; a_ready = !b_valid.
REQ-023: In NORM, a cycle with b_valid=1 and b_ready=0 increments starve_cnt; a B transfer clears starve_cnt; b_valid=0 holds starve_cnt.
REQ-024: In NORM, the state moves to BOOST on the edge where the incremented starve_cnt equals STARVE_MAX; starve_cnt then clears.
REQ-025: In BOOST, the state returns to NORM after one B transfer, or on any cycle with b_valid=0 (no transfer); starve_cnt stays 0.
REQ-026: Output latency is exactly 1 cycle. On the edge after a transfer, wr_addr, wr_data and wr_sel load the granted requester's values, and wr_en = 1.
REQ-027: A transfer with address 5'd31 is accepted (ready asserted), but the next cycle has wr_en = 0. On that cycle wr_addr, wr_data and wr_sel still update (hard-zero register discard).
REQ-028: A cycle with no transfer gives wr_en = 0 on the next cycle. wr_addr, wr_data and wr_sel hold their previous values.
REQ-029: If A and B target the same address on the same cycle, only the winner is written. The loser retries on a later cycle; no merging or reordering of a single requester's transfers.
REQ-030: When both are idle, the block holds its state and counter without change.

Reset
REQ-031: When reset_n is asserted low, asynchronously: state = NORM, starve_cnt = 0, wr_en = 0, wr_sel = 0, wr_addr = 0, wr_data = 0, boost = 0.
REQ-032: While reset_n = 0, a_ready = 0 and b_ready = 0 (no transfers accepted).
REQ-033: If reset is asserted mid-operation, any registered write is discarded. The first cycle after reset_n deasserts behaves as NORM with starve_cnt = 0.

Verification
REQ-034: A only: a_valid=1, a_addr=3, a_data=0x55 for 1 cycle -> a_ready=1 that cycle; next cycle wr_en=1, wr_sel=0, wr_addr=3, wr_data=0x55.
REQ-035: Contention, STARVE_MAX=4: a_valid and b_valid held high, with b_addr=7 -> A wins for 4 cycles and boost rises. On the 5th cycle b_ready=1 and a_ready=0. The next cycle gives wr_sel=1, wr_addr=7, then the arbiter returns to NORM.
REQ-036: XZR discard: b_valid=1, b_addr=31, a_valid=0 -> b_ready=1; next cycle wr_en=0, wr_addr=31.
REQ-037: BOOST abandon: reach BOOST, then drop b_valid with a_valid=1 -> a_ready=1 that cycle, state returns to NORM, starve_cnt=0.
REQ-038: Reset mid-stream: during alternating transfers, pull reset_n low asynchronously between edges -> wr_en, boost and both readys go to 0 immediately. After release, an A request is granted first with 1-cycle latency.
REQ-039: Idle/hold: after a write of addr 9, data 0x1234, drive no valids for 3 cycles -> wr_en=0 and wr_addr=9, wr_data=0x1234 held; starve_cnt unchanged.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file writeback port bundle: two requesters (A = pipeline, B = long-latency unit)
// plus the registered write port that drives the register file.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              a_valid;
  logic [4:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [4:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              wr_en;
  logic              wr_sel;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              boost;

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    input  wr_en, wr_sel, wr_addr, wr_data, boost
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    output wr_en, wr_sel, wr_addr, wr_data, boost
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-requester register-file write port arbiter: A normally wins, B is boosted to priority
// for one cycle after losing STARVE_MAX consecutive cycles. Writes leave one cycle after grant.
module wb_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic {
    NORM  = 1'b0,
    BOOST = 1'b1
  } state_t;

  localparam logic [4:0] XZR_ADDR   = 5'd31;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt, starve_inc;
  logic              a_rdy, b_rdy;
  logic              a_xfer, b_xfer;
  logic              win_sel;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;

  // Readys depend only on state and the opposing valid; both are held low during reset.
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (reset_n) begin
      if (state == BOOST) begin
        b_rdy = 1'b1;
        a_rdy = !bus.b_valid;
      end else begin
        a_rdy = 1'b1;
        b_rdy = !bus.a_valid;
      end
    end
  end

  assign a_xfer      = bus.a_valid && a_rdy;
  assign b_xfer      = bus.b_valid && b_rdy;
  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.boost   = (state == BOOST);

  always_comb begin
    win_sel  = b_xfer;
    win_addr = b_xfer ? bus.b_addr : bus.a_addr;
    win_data = b_xfer ? bus.b_data : bus.a_data;
  end

  // BOOST always lasts a single cycle: B is either granted or has gone away.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    starve_inc = starve_cnt + 4'd1;
    if (state == BOOST) begin
      starve_nxt = 4'd0;
      if (b_xfer || !bus.b_valid) begin
        state_nxt = NORM;
      end
    end else if (b_xfer) begin
      starve_nxt = 4'd0;
    end else if (bus.b_valid) begin
      if (starve_inc == STARVE_LIM) begin
        state_nxt  = BOOST;
        starve_nxt = 4'd0;
      end else begin
        starve_nxt = starve_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= NORM;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Register 31 is hard-zero: the transfer is still captured but the write enable is suppressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_sel  <= 1'b0;
      bus.wr_addr <= 5'd0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      if (a_xfer || b_xfer) begin
        bus.wr_en   <= (win_addr != XZR_ADDR);
        bus.wr_sel  <= win_sel;
        bus.wr_addr <= win_addr;
        bus.wr_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_port_arbiter;

  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  wb_port_arbiter_if #(.DATA_W(DATA_W)) bus ();

  wb_port_arbiter #(
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: B has priority for exactly one cycle after STARVE_MAX consecutive losses.
  bit          m_b_first;
  int          m_lost;
  logic        m_wr_en;
  logic        m_wr_sel;
  logic [4:0]  m_wr_addr;
  logic [63:0] m_wr_data;

  function automatic logic [1:0] modelGrant(input bit bfirst, input logic av, input logic bv);
    if (bfirst) return bv ? 2'b10 : (av ? 2'b01 : 2'b00);
    return av ? 2'b01 : (bv ? 2'b10 : 2'b00);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_b_first <= 1'b0;
      m_lost    <= 0;
      m_wr_en   <= 1'b0;
      m_wr_sel  <= 1'b0;
      m_wr_addr <= 5'd0;
      m_wr_data <= 64'd0;
    end else begin
      if (modelGrant(m_b_first, bus.a_valid, bus.b_valid) == 2'b01) begin
        m_wr_en   <= (bus.a_addr != 5'd31);
        m_wr_sel  <= 1'b0;
        m_wr_addr <= bus.a_addr;
        m_wr_data <= bus.a_data;
      end else if (modelGrant(m_b_first, bus.a_valid, bus.b_valid) == 2'b10) begin
        m_wr_en   <= (bus.b_addr != 5'd31);
        m_wr_sel  <= 1'b1;
        m_wr_addr <= bus.b_addr;
        m_wr_data <= bus.b_data;
      end else begin
        m_wr_en <= 1'b0;
      end
      if (m_b_first) begin
        m_b_first <= 1'b0;
      end else if (modelGrant(m_b_first, bus.a_valid, bus.b_valid) == 2'b10) begin
        m_lost <= 0;
      end else if (bus.b_valid) begin
        if (m_lost + 1 == STARVE_MAX) begin
          m_b_first <= 1'b1;
          m_lost    <= 0;
        end else begin
          m_lost <= m_lost + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [63:0] bd);
    @(posedge clk);
    #1;
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
  endtask

  // Every-cycle comparison of all outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_a, exp_b;
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (reset_n) begin
      exp_a = m_b_first ? !bus.b_valid : 1'b1;
      exp_b = m_b_first ? 1'b1 : !bus.a_valid;
    end
    checkOutput("model_a_ready", 64'(bus.a_ready), 64'(exp_a));
    checkOutput("model_b_ready", 64'(bus.b_ready), 64'(exp_b));
    checkOutput("model_boost",   64'(bus.boost),   64'(m_b_first));
    checkOutput("model_wr_en",   64'(bus.wr_en),   64'(m_wr_en));
    checkOutput("model_wr_sel",  64'(bus.wr_sel),  64'(m_wr_sel));
    checkOutput("model_wr_addr", 64'(bus.wr_addr), 64'(m_wr_addr));
    checkOutput("model_wr_data", bus.wr_data,      m_wr_data);
    checkOutput("model_starve",  64'(dut.starve_cnt), 64'(m_lost));
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd1;
    bus.a_data  = 64'h11;
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'd2;
    bus.b_data  = 64'h22;

    // Reset values, with both valids high to show readys are gated.
    @(negedge clk);
    checkOutput("rst_wr_en",   64'(bus.wr_en),   64'd0);
    checkOutput("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("rst_wr_data", bus.wr_data,      64'd0);
    checkOutput("rst_boost",   64'(bus.boost),   64'd0);
    checkOutput("rst_a_ready", 64'(bus.a_ready), 64'd0);
    checkOutput("rst_b_ready", 64'(bus.b_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;

    $display("[TB] A-only write");
    applyStimulus(1, 5'd3, 64'h55, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("aonly_a_ready", 64'(bus.a_ready), 64'd1);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("aonly_wr_en",   64'(bus.wr_en),   64'd1);
    checkOutput("aonly_wr_sel",  64'(bus.wr_sel),  64'd0);
    checkOutput("aonly_wr_addr", 64'(bus.wr_addr), 64'd3);
    checkOutput("aonly_wr_data", bus.wr_data,      64'h55);

    $display("[TB] Contention until boost");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 5'd1, 64'hA1, 1, 5'd7, 64'hB7);
      @(negedge clk);
      checkOutput("cont_a_ready", 64'(bus.a_ready), 64'd1);
      checkOutput("cont_b_ready", 64'(bus.b_ready), 64'd0);
      checkOutput("cont_boost",   64'(bus.boost),   64'd0);
    end
    applyStimulus(1, 5'd1, 64'hA1, 1, 5'd7, 64'hB7);
    @(negedge clk);
    checkOutput("cont5_boost",   64'(bus.boost),   64'd1);
    checkOutput("cont5_b_ready", 64'(bus.b_ready), 64'd1);
    checkOutput("cont5_a_ready", 64'(bus.a_ready), 64'd0);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("cont_wr_sel",  64'(bus.wr_sel),  64'd1);
    checkOutput("cont_wr_addr", 64'(bus.wr_addr), 64'd7);
    checkOutput("cont_wr_data", bus.wr_data,      64'hB7);
    checkOutput("cont_norm",    64'(bus.boost),   64'd0);

    $display("[TB] Hard-zero discard");
    applyStimulus(0, 5'd0, 64'h0, 1, 5'd31, 64'hDEAD);
    @(negedge clk);
    checkOutput("xzr_b_ready", 64'(bus.b_ready), 64'd1);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("xzr_wr_en",   64'(bus.wr_en),   64'd0);
    checkOutput("xzr_wr_addr", 64'(bus.wr_addr), 64'd31);
    checkOutput("xzr_wr_data", bus.wr_data,      64'hDEAD);

    $display("[TB] Boost abandon");
    for (int i = 0; i < 4; i++) applyStimulus(1, 5'd2, 64'hA2, 1, 5'd8, 64'hB8);
    applyStimulus(1, 5'd2, 64'hA3, 0, 5'd8, 64'hB8);
    @(negedge clk);
    checkOutput("abandon_boost",   64'(bus.boost),   64'd1);
    checkOutput("abandon_a_ready", 64'(bus.a_ready), 64'd1);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("abandon_norm",   64'(bus.boost),      64'd0);
    checkOutput("abandon_starve", 64'(dut.starve_cnt), 64'd0);
    checkOutput("abandon_wr_sel", 64'(bus.wr_sel),     64'd0);
    checkOutput("abandon_wr_dat", bus.wr_data,         64'hA3);

    $display("[TB] Idle hold");
    for (int i = 0; i < 2; i++) applyStimulus(1, 5'd4, 64'hA4, 1, 5'd10, 64'hBA);
    applyStimulus(1, 5'd9, 64'h1234, 0, 5'd0, 64'h0);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("hold_first_en", 64'(bus.wr_en), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
      @(negedge clk);
      checkOutput("hold_wr_en",   64'(bus.wr_en),      64'd0);
      checkOutput("hold_wr_addr", 64'(bus.wr_addr),    64'd9);
      checkOutput("hold_wr_data", bus.wr_data,         64'h1234);
      checkOutput("hold_starve",  64'(dut.starve_cnt), 64'd2);
    end

    $display("[TB] Reset mid-stream");
    applyStimulus(1, 5'd5, 64'hA5, 0, 5'd0, 64'h0);
    applyStimulus(0, 5'd0, 64'h0, 1, 5'd6, 64'hB6);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en",   64'(bus.wr_en),   64'd0);
    checkOutput("midrst_boost",   64'(bus.boost),   64'd0);
    checkOutput("midrst_a_ready", 64'(bus.a_ready), 64'd0);
    checkOutput("midrst_b_ready", 64'(bus.b_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd12;
    bus.a_data  = 64'hC;
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'd13;
    bus.b_data  = 64'hD;
    @(negedge clk);
    checkOutput("postrst_a_ready", 64'(bus.a_ready), 64'd1);
    checkOutput("postrst_b_ready", 64'(bus.b_ready), 64'd0);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    checkOutput("postrst_wr_en",   64'(bus.wr_en),   64'd1);
    checkOutput("postrst_wr_sel",  64'(bus.wr_sel),  64'd0);
    checkOutput("postrst_wr_addr", 64'(bus.wr_addr), 64'd12);

    $display("[TB] Randomized traffic");
    for (int i = 0; i < 800; i++) begin
      logic [4:0] aa, ba;
      aa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      ba = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 31));
      applyStimulus(logic'($urandom_range(0, 3) != 0), aa, {$urandom, $urandom},
                    logic'($urandom_range(0, 2) != 0), ba, {$urandom, $urandom});
    end
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    applyStimulus(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
